// File: rtl/alg_amba_vip_pkg.sv
// Shared AXI widths and W-channel FSM state type for the VIP limiter slice.
package alg_amba_vip_pkg;
  localparam int AXI_ADDR_W  = 64;
  localparam int AXI_ID_W    = 5;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;
  // Outstanding counters cover 0..31
  localparam int CNT_W       = 5;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } w_state_t;
endpackage

// File: rtl/al_vip_axi_if.sv
// AXI4 bundle with master/slave views used on both sides of the limiter.
interface al_vip_axi_if import alg_amba_vip_pkg::*; #(
  parameter int DATA_WIDTH = 128
) ();
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [AXI_LEN_W-1:0]    awlen;
  logic [AXI_SIZE_W-1:0]   awsize;
  logic [AXI_BURST_W-1:0]  awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [AXI_ID_W-1:0]     bid;
  logic [AXI_RESP_W-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;

  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [AXI_LEN_W-1:0]    arlen;
  logic [AXI_SIZE_W-1:0]   arsize;
  logic [AXI_BURST_W-1:0]  arburst;
  logic                    arvalid;
  logic                    arready;

  logic [AXI_ID_W-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [AXI_RESP_W-1:0]   rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport mastermod (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slavemod (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/alg_amba_vip_sync_fifo.sv
// Small synchronous FIFO; a push is accepted while full if a pop happens in the same cycle.
module alg_amba_vip_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = r_mem[r_rptr];

  // Storage carries no reset; occupancy alone says what is valid
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= din;

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_next(r_wptr);
      if (w_pop)  r_rptr <= ptr_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
endmodule

// File: rtl/alg_amba_vip_ot_limiter.sv
// Outstanding-transaction limiter between the VIP pipe stage and the DUT.
// Payload flows through combinationally; only AR/AW/W valid/ready are gated.
module alg_amba_vip_ot_limiter import alg_amba_vip_pkg::*; #(
  parameter int MAX_OUT_RD = 8,
  parameter int MAX_OUT_WR = 8,
  parameter int DATA_WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  al_vip_axi_if.slavemod   s_axi,
  al_vip_axi_if.mastermod  m_axi,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic [CNT_W-1:0] wr_outstanding,
  output logic             err_rd_underflow,
  output logic             err_wr_underflow,
  output logic             err_wlast
);
  logic [CNT_W-1:0]     r_rd_cnt, r_wr_cnt;
  logic                 r_err_rd_uf, r_err_wr_uf, r_err_wlast;
  w_state_t             r_wstate;
  logic [AXI_LEN_W-1:0] r_beat_cnt;

  logic                 w_rd_ok, w_wr_ok, w_w_ok;
  logic                 w_ar_hs, w_r_done, w_aw_hs, w_b_hs, w_w_hs, w_pop;
  logic                 w_fifo_full, w_fifo_empty;
  logic [AXI_LEN_W-1:0] w_head, w_beat_idx;
  logic                 w_wlast_bad;
  logic [DATA_WIDTH-1:0] w_wdata, w_rdata;

  // Payload pass-through, both directions
  assign m_axi.awid    = s_axi.awid;
  assign m_axi.awaddr  = s_axi.awaddr;
  assign m_axi.awlen   = s_axi.awlen;
  assign m_axi.awsize  = s_axi.awsize;
  assign m_axi.awburst = s_axi.awburst;
  assign w_wdata       = s_axi.wdata;
  assign m_axi.wdata   = w_wdata;
  assign m_axi.wstrb   = s_axi.wstrb;
  assign m_axi.wlast   = s_axi.wlast;
  assign m_axi.arid    = s_axi.arid;
  assign m_axi.araddr  = s_axi.araddr;
  assign m_axi.arlen   = s_axi.arlen;
  assign m_axi.arsize  = s_axi.arsize;
  assign m_axi.arburst = s_axi.arburst;
  assign s_axi.bid     = m_axi.bid;
  assign s_axi.bresp   = m_axi.bresp;
  assign s_axi.bvalid  = m_axi.bvalid;
  assign m_axi.bready  = s_axi.bready;
  assign s_axi.rid     = m_axi.rid;
  assign w_rdata       = m_axi.rdata;
  assign s_axi.rdata   = w_rdata;
  assign s_axi.rresp   = m_axi.rresp;
  assign s_axi.rlast   = m_axi.rlast;
  assign s_axi.rvalid  = m_axi.rvalid;
  assign m_axi.rready  = s_axi.rready;

  // Gates are forced closed while reset is high
  assign w_rd_ok = ~rst & (r_rd_cnt < CNT_W'(MAX_OUT_RD));
  assign w_wr_ok = ~rst & (r_wr_cnt < CNT_W'(MAX_OUT_WR)) & ~w_fifo_full;
  // FIFO is only written on the clock edge, so W never bypasses its own AW
  assign w_w_ok  = ~rst & ~w_fifo_empty;

  assign m_axi.arvalid = s_axi.arvalid & w_rd_ok;
  assign s_axi.arready = m_axi.arready & w_rd_ok;
  assign m_axi.awvalid = s_axi.awvalid & w_wr_ok;
  assign s_axi.awready = m_axi.awready & w_wr_ok;
  assign m_axi.wvalid  = s_axi.wvalid  & w_w_ok;
  assign s_axi.wready  = m_axi.wready  & w_w_ok;

  assign w_ar_hs  = s_axi.arvalid & m_axi.arready & w_rd_ok;
  assign w_r_done = m_axi.rvalid & s_axi.rready & m_axi.rlast;
  assign w_aw_hs  = s_axi.awvalid & m_axi.awready & w_wr_ok;
  assign w_b_hs   = m_axi.bvalid & s_axi.bready;
  assign w_w_hs   = s_axi.wvalid & m_axi.wready & w_w_ok;
  assign w_pop    = w_w_hs & s_axi.wlast;

  alg_amba_vip_sync_fifo #(
    .WIDTH (AXI_LEN_W),
    .DEPTH (MAX_OUT_WR)
  ) u_awlen_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_aw_hs),
    .din   (s_axi.awlen),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Beat index of the current W beat; idle means the next beat is the first
  assign w_beat_idx  = (r_wstate == W_IDLE) ? '0 : r_beat_cnt;
  assign w_wlast_bad = w_w_hs & (s_axi.wlast ? (w_beat_idx != w_head)
                                             : (w_beat_idx == w_head));

  // Read outstanding counter, saturating at 0 with sticky underflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd_cnt    <= '0;
      r_err_rd_uf <= 1'b0;
    end else begin
      case ({w_ar_hs, w_r_done})
        2'b10:   r_rd_cnt <= r_rd_cnt + 1'b1;
        2'b01:   if (r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - 1'b1;
        default: r_rd_cnt <= r_rd_cnt;
      endcase
      if (w_r_done && r_rd_cnt == '0) r_err_rd_uf <= 1'b1;
    end

  // Write outstanding counter (AW in, B out), saturating at 0 with sticky underflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_cnt    <= '0;
      r_err_wr_uf <= 1'b0;
    end else begin
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_wr_cnt <= r_wr_cnt + 1'b1;
        2'b01:   if (r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - 1'b1;
        default: r_wr_cnt <= r_wr_cnt;
      endcase
      if (w_b_hs && r_wr_cnt == '0) r_err_wr_uf <= 1'b1;
    end

  // W burst tracker: counts beats, ends only on wlast, flags wlast/awlen disagreement
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wstate    <= W_IDLE;
      r_beat_cnt  <= '0;
      r_err_wlast <= 1'b0;
    end else begin
      if (w_wlast_bad) r_err_wlast <= 1'b1;
      if (w_w_hs) begin
        if (s_axi.wlast) begin
          r_wstate   <= W_IDLE;
          r_beat_cnt <= '0;
        end else begin
          r_wstate   <= W_BURST;
          r_beat_cnt <= w_beat_idx + 1'b1;
        end
      end
    end

  assign rd_outstanding   = r_rd_cnt;
  assign wr_outstanding   = r_wr_cnt;
  assign err_rd_underflow = r_err_rd_uf;
  assign err_wr_underflow = r_err_wr_uf;
  assign err_wlast        = r_err_wlast;
endmodule

// File: doc/alg_amba_vip_ot_limiter.md
ALG_AMBA_VIP_OT_LIMITER -- requirements
Module: alg_amba_vip_ot_limiter

Interface
REQ-001 SHALL have parameter MAX_OUT_RD, default 8: maximum outstanding read bursts, range 1..31.
REQ-002 SHALL have parameter MAX_OUT_WR, default 8: maximum outstanding write bursts, range 1..31.
REQ-003 SHALL have parameter DATA_WIDTH, default 128: AXI data width.
REQ-004 SHALL have port clk  in  1  sole clock; one clock, all state rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port s_axi  al_vip_axi_if.slavemod  addr 64, id 5, len 8, size 3, burst 2, resp 2, data DATA_WIDTH  upstream AXI side, fed by the VIP pipe stage.
REQ-007 SHALL have port m_axi  al_vip_axi_if.mastermod  same widths  downstream AXI side toward the DUT.
REQ-008 SHALL have port rd_outstanding  out  5  current outstanding read bursts.
REQ-009 SHALL have port wr_outstanding  out  5  current outstanding write bursts.
REQ-010 SHALL have port err_rd_underflow  out  1  sticky: R last-beat with no read outstanding.
REQ-011 SHALL have port err_wr_underflow  out  1  sticky: B with no write outstanding.
REQ-012 SHALL have port err_wlast  out  1  sticky: wlast position disagrees with awlen.

Function
REQ-013 SHALL pass all payload fields unchanged and combinationally (zero latency) in both directions.
REQ-014 SHALL gate AR: m_axi.arvalid = s_axi.arvalid AND rd_cnt<MAX_OUT_RD; s_axi.arready = m_axi.arready AND rd_cnt<MAX_OUT_RD.
REQ-015 SHALL gate AW the same way against wr_cnt<MAX_OUT_WR AND awlen FIFO not full.
REQ-016 SHALL increment rd_cnt on AR handshake and decrement it on R handshake with rlast; both in one cycle leave it unchanged.
REQ-017 SHALL increment wr_cnt on AW handshake and decrement it on B handshake; both in one cycle leave it unchanged.
REQ-018 SHALL never wrap a counter below 0; a decrement at 0 keeps 0 and sets the matching underflow flag.
REQ-019 SHALL push awlen into an awlen FIFO of depth MAX_OUT_WR on each AW handshake.
REQ-020 SHALL gate W: m_axi.wvalid = s_axi.wvalid AND FIFO not empty; s_axi.wready = m_axi.wready AND FIFO not empty. No same-cycle AW-to-W bypass, so first W beat is accepted no earlier than 1 cycle after its AW handshake.
REQ-021 SHALL run a W FSM: W_IDLE (beat_cnt=0, waiting for non-empty FIFO) -> W_BURST on first W handshake; W_BURST -> W_IDLE on W handshake with wlast (FIFO pop), else stay and increment beat_cnt.
REQ-022 SHALL set err_wlast when a W handshake has wlast=1 with beat_cnt != FIFO head, or wlast=0 with beat_cnt == FIFO head; the burst still ends only on wlast.
REQ-023 SHALL allow FIFO push and pop in the same cycle, including when full.
REQ-024 SHALL drive rd_outstanding/wr_outstanding directly from the counters, registered, not combinational.
REQ-025 SHALL pass B and R channels ungated.

Reset
REQ-026 SHALL on rst clear rd_cnt, wr_cnt, beat_cnt, all error flags, empty the FIFO and enter W_IDLE, asynchronously.
REQ-027 SHALL during rst hold m_axi.arvalid, awvalid, wvalid and s_axi.arready, awready, wready at 0.
REQ-028 SHALL clear error flags only by reset.
REQ-029 SHALL drop in-flight transaction state when rst is asserted mid-burst, with no recovery.

Structure
REQ-030 SHALL place the AXI width constants (ADDR 64, ID 5, LEN 8, SIZE 3, BURST 2, RESP 2) and the W FSM state enum in shared package alg_amba_vip_pkg.
REQ-031 SHALL implement the awlen FIFO as sub-module alg_amba_vip_sync_fifo (parameters WIDTH, DEPTH; outputs full, empty).

Verification
REQ-032 SHALL verify: MAX_OUT_RD=2, 3 back-to-back ARs with no R -> third AR held (arready=0), rd_outstanding=2; after one rlast beat, third AR accepted.
REQ-033 SHALL verify: same-cycle AR handshake and rlast handshake at rd_cnt=2 -> rd_cnt stays 2.
REQ-034 SHALL verify: AW awlen=3, then 4 W beats with wlast on beat 4 -> err_wlast=0, FIFO empty, FSM W_IDLE.
REQ-035 SHALL verify: W presented before any AW -> wready=0 until 1 cycle after AW handshake.
REQ-036 SHALL verify: B with wr_cnt=0 -> err_wr_underflow=1 sticky, wr_outstanding stays 0.
REQ-037 SHALL verify: awlen=1 burst with wlast on beat 1 -> err_wlast=1; rst mid-burst -> all flags 0, counters 0.
